serial_alu_seq: RTL and testbench

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/alu_pkg.sv | 28 ++
 rtl/one_bit_ALU.sv | 33 +++
 rtl/serial_alu_seq.sv | 137 +++++++++++++
 tb/tb_serial_alu_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code constants, select fields and FSM state encoding for the serial ALU.
package alu_pkg;

  // op[1:0] select field
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_SLT = 2'b11;

  // Full op codes: {Ainvert, Bnegate, select}
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_add(input logic [1:0] sel);
    return sel == SEL_ADD;
  endfunction

endpackage

// File: rtl/one_bit_ALU.sv
// 1-bit ALU cell: optional operand inversion, AND/OR/full-add/less select.
module one_bit_ALU (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       ainvert,
  input  logic       bnegate,
  input  logic [1:0] sel,
  input  logic       less,
  output logic       res,
  output logic       cout
);
  import alu_pkg::*;

  logic aa;
  logic bb;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ bnegate;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    res = 1'b0;
    unique case (sel)
      SEL_AND: res = aa & bb;
      SEL_OR:  res = aa | bb;
      SEL_ADD: res = aa ^ bb ^ cin;
      SEL_SLT: res = less;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one bit per cycle through a single 1-bit cell, LSB first.
// Define SERIAL_ALU_OVF_EN to enable signed-overflow tracking on add/sub.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             step;
  logic             finish;
  logic             last_bit;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             slice_res;
  logic             slice_cout;

  assign last_bit = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath strobes
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  one_bit_ALU u_slice (
    .a       (a_q[idx]),
    .b       (b_q[idx]),
    .cin     (carry),
    .ainvert (op_q[3]),
    .bnegate (op_q[2]),
    .sel     (op_q[1:0]),
    .less    (1'b0),
    .res     (slice_res),
    .cout    (slice_cout)
  );

  // Operand latch, bit walk, result shift and flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
    end else begin
      busy <= (next_state == RUN);
      done <= finish;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        idx   <= '0;
        carry <= op[2];
      end
      if (step) begin
        result <= {slice_res, result[WIDTH-1:1]};
        idx    <= last_bit ? '0 : idx + IDX_W'(1);
        carry  <= is_add(op_q[1:0]) ? slice_cout : 1'b0;
      end
      if (finish) begin
        zero      <= (result == '0);
        carry_out <= is_add(op_q[1:0]) & carry;
      end
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic ovf_pend;

  // Carry into MSB xor carry out of MSB, captured on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (step && last_bit) ovf_pend <= carry ^ slice_cout;
      if (finish)           overflow <= is_add(op_q[1:0]) & ovf_pend;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed self-checking bench for serial_alu_seq (WIDTH=8).
module tb_serial_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 8;

`ifdef SERIAL_ALU_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive a start for one cycle, then scramble the operand inputs.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] top);
    @(negedge clk);
    rst_n = 1'b1;
    a     = ta;
    b     = tb;
    op    = top;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ta;
    b     = 8'hA5;
    op    = OP_OR;
  endtask

  // Watch a fixed window after the start edge, recording done latency and pulse count.
  task automatic track(input bit second_start, input bit poke_done);
    int n;
    n      = 0;
    lat    = 0;
    pulses = 0;
    check("busy_in_run", 32'(busy), 32'd1);
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (second_start && n == 3) start = 1'b1;
      if (second_start && n == 4) start = 1'b0;
      if (poke_done && n == W) start = 1'b1;
      if (poke_done && n == W + 1) begin
        start = 1'b0;
        check("busy_after_done_start", 32'(busy), 32'd0);
      end
      if (done) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    check("done_latency", 32'(lat), 32'(W + 1));
    check("done_pulses", 32'(pulses), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic z,
                            input logic c, input logic v);
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_zero"}, 32'(zero), 32'(z));
    check({tag, "_carry"}, 32'(carry_out), 32'(c));
    check({tag, "_ovf"}, 32'(overflow), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    expect_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);

    launch(8'h7F, 8'h01, OP_ADD);
    track(1'b0, 1'b0);
    expect_out("add_ovf", 8'h80, 1'b0, 1'b0, OVF_EN);

    launch(8'h05, 8'h05, OP_SUB);
    track(1'b0, 1'b1);
    expect_out("sub_eq", 8'h00, 1'b1, 1'b1, 1'b0);

    launch(8'hF0, 8'h3C, OP_AND);
    track(1'b0, 1'b0);
    expect_out("and", 8'h30, 1'b0, 1'b0, 1'b0);

    launch(8'hF0, 8'h3C, OP_OR);
    track(1'b0, 1'b0);
    expect_out("or", 8'hFC, 1'b0, 1'b0, 1'b0);

    launch(8'h00, 8'h00, OP_NOR);
    track(1'b0, 1'b0);
    expect_out("nor", 8'hFF, 1'b0, 1'b0, 1'b0);

    launch(8'h03, 8'h05, OP_SLT);
    track(1'b0, 1'b0);
    expect_out("slt", 8'h00, 1'b1, 1'b0, 1'b0);

    launch(8'h12, 8'h34, OP_ADD);
    track(1'b1, 1'b0);
    expect_out("second_start", 8'h46, 1'b0, 1'b0, 1'b0);

    // Reset while the walk is at bit 4
    launch(8'h11, 8'h22, OP_ADD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    expect_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    launch(8'h03, 8'h04, OP_ADD);
    track(1'b0, 1'b0);
    expect_out("post_rst", 8'h07, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
